// File: rtl/muldiv_pkg.sv
// Shared types and default timing constants for the multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_MULT = 2'b01,
        OP_DIV  = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int DEF_RUN_CYCLES = 33;
    localparam int DEF_TIMEOUT    = 8;
    localparam int DEF_CNT_W      = 6;

endpackage

// File: rtl/muldiv_sequencer.sv
// Drives the shared multi-cycle multiplier/divider for one request at a time and
// captures the 64-bit result into architectural Hi/Lo.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int RUN_CYCLES = DEF_RUN_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic [1:0]  Op,
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    output logic        MultControl,
    output logic        MultReset,
    input  logic        MultDone,
    input  logic [31:0] MultHi,
    input  logic [31:0] MultLo,
    output logic        DivControl,
    output logic        DivReset,
    input  logic        DivDone,
    input  logic [31:0] DivHi,
    input  logic [31:0] DivLo,
    output logic [31:0] UnitA,
    output logic [31:0] UnitB,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Busy,
    output logic        Done,
    output logic        DivZero,
    output logic        Timeout
);

    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [31:0]       unit_a_reg, unit_a_next;
    logic [31:0]       unit_b_reg, unit_b_next;
    logic              sel_div_reg, sel_div_next;
    logic              div_zero_reg, div_zero_next;
    logic              timeout_reg, timeout_next;
    logic [31:0]       hi_reg, lo_reg;
    logic              hilo_load;
    logic              unit_done;
    op_t               op_in;

    // Index 0 is the multiplier, index 1 the divider.
    logic [1:0] unit_sel, unit_ctl, unit_clr;

    assign op_in     = op_t'(Op);
    assign unit_sel  = {sel_div_reg, ~sel_div_reg};
    assign unit_done = sel_div_reg ? DivDone : MultDone;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unit
            assign unit_ctl[gi] = unit_sel[gi] && (state_reg == ST_RUN);
            assign unit_clr[gi] = Reset || (unit_sel[gi] && (state_reg == ST_CLEAR));
        end
    endgenerate

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            unit_a_reg   <= '0;
            unit_b_reg   <= '0;
            sel_div_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
            timeout_reg  <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            unit_a_reg   <= unit_a_next;
            unit_b_reg   <= unit_b_next;
            sel_div_reg  <= sel_div_next;
            div_zero_reg <= div_zero_next;
            timeout_reg  <= timeout_next;
            if (hilo_load) begin
                hi_reg <= sel_div_reg ? DivHi : MultHi;
                lo_reg <= sel_div_reg ? DivLo : MultLo;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        unit_a_next   = unit_a_reg;
        unit_b_next   = unit_b_reg;
        sel_div_next  = sel_div_reg;
        div_zero_next = div_zero_reg;
        timeout_next  = timeout_reg;
        hilo_load     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (Req && (op_in == OP_MULT || op_in == OP_DIV)) begin
                    unit_a_next   = OpA;
                    unit_b_next   = OpB;
                    sel_div_next  = (op_in == OP_DIV);
                    div_zero_next = 1'b0;
                    timeout_next  = 1'b0;
                    cnt_next      = '0;
                    // A zero divisor never reaches the divider.
                    if (op_in == OP_DIV && OpB == '0) begin
                        div_zero_next = 1'b1;
                        state_next    = ST_DONE;
                    end else begin
                        state_next = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                cnt_next   = '0;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_reg == RUN_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_DRAIN;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (unit_done) begin
                    hilo_load  = 1'b1;
                    state_next = ST_DONE;
                end else if (cnt_reg == TO_LAST) begin
                    cnt_next     = '0;
                    timeout_next = 1'b1;
                    state_next   = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign MultControl = unit_ctl[0];
    assign DivControl  = unit_ctl[1];
    assign MultReset   = unit_clr[0];
    assign DivReset    = unit_clr[1];
    assign UnitA       = unit_a_reg;
    assign UnitB       = unit_b_reg;
    assign Hi          = hi_reg;
    assign Lo          = lo_reg;
    assign Busy        = (state_reg != ST_IDLE);
    assign Done        = (state_reg == ST_DONE);
    assign DivZero     = div_zero_reg;
    assign Timeout     = timeout_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with simple multiplier/divider models.
module tb_muldiv_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Req = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] OpA = '0, OpB = '0;
    logic        MultControl, MultReset, DivControl, DivReset;
    logic        MultDone, DivDone;
    logic [31:0] MultHi, MultLo, DivHi, DivLo;
    logic [31:0] UnitA, UnitB, Hi, Lo;
    logic        Busy, Done, DivZero, Timeout;

    int checks = 0;
    int passed = 0;
    int n_mrst, n_mctl, n_drst, n_dctl;
    int lat;
    bit div_never = 1'b0;

    always #5 Clk = ~Clk;

    muldiv_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Op(Op), .OpA(OpA), .OpB(OpB),
        .MultControl(MultControl), .MultReset(MultReset), .MultDone(MultDone),
        .MultHi(MultHi), .MultLo(MultLo),
        .DivControl(DivControl), .DivReset(DivReset), .DivDone(DivDone),
        .DivHi(DivHi), .DivLo(DivLo),
        .UnitA(UnitA), .UnitB(UnitB), .Hi(Hi), .Lo(Lo),
        .Busy(Busy), .Done(Done), .DivZero(DivZero), .Timeout(Timeout)
    );

    // Unit models: done rises one edge after the enable falls, cleared by local reset.
    logic mdone = 1'b0, ddone = 1'b0, mctl_d = 1'b0, dctl_d = 1'b0;
    logic [63:0] prod;
    assign prod = $signed({{32{UnitA[31]}}, UnitA}) * $signed({{32{UnitB[31]}}, UnitB});
    assign MultDone = mdone;
    assign DivDone  = ddone;
    assign {MultHi, MultLo} = mdone ? prod : 64'hDEADBEEF_DEADBEEF;
    assign {DivHi, DivLo}   = ddone ? {UnitA % UnitB, UnitA / UnitB} : 64'hDEADBEEF_DEADBEEF;

    always @(posedge Clk) begin
        if (MultReset) mdone <= 1'b0;
        else if (mctl_d && !MultControl) mdone <= 1'b1;
        mctl_d <= MultControl;
        if (DivReset) ddone <= 1'b0;
        else if (dctl_d && !DivControl && !div_never) ddone <= 1'b1;
        dctl_d <= DivControl;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Issues one request and waits (bounded) for Done; lat=0 means Done never came.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        Req = 1'b1; Op = op; OpA = a; OpB = b;
        lat = 0; n_mrst = 0; n_mctl = 0; n_drst = 0; n_dctl = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge Clk);
            Req = 1'b0;
            n_mrst += int'(MultReset);
            n_mctl += int'(MultControl);
            n_drst += int'(DivReset);
            n_dctl += int'(DivControl);
            if (Done) begin
                lat = c;
                break;
            end
        end
        $display("op=%0d A=0x%08h B=0x%08h lat=%0d Hi=0x%08h Lo=0x%08h DivZero=%0b Timeout=%0b",
                 op, a, b, lat, Hi, Lo, DivZero, Timeout);
    endtask

    initial begin
        int dn, d1, d2;
        // Reset state
        repeat (2) @(negedge Clk);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_hilo", {Hi, Lo}, 0);
        chk("rst_mreset", MultReset, 1);
        chk("rst_dreset", DivReset, 1);
        chk("rst_ctl", {MultControl, DivControl}, 0);
        chk("rst_unit", {UnitA, UnitB}, 0);
        Reset = 1'b0;

        // NOP and reserved requests are ignored
        @(negedge Clk); Req = 1'b1; Op = 2'b00;
        @(negedge Clk); Op = 2'b11;
        @(negedge Clk); Req = 1'b0;
        chk("nop_busy", Busy, 0);

        do_op(2'b01, 32'd3, 32'd5);
        chk("mul_lat", lat, 37);
        chk("mul_mrst_cycles", n_mrst, 1);
        chk("mul_mctl_cycles", n_mctl, 33);
        chk("mul_div_untouched", n_dctl + n_drst, 0);
        chk("mul_hilo", {Hi, Lo}, 64'h00000000_0000000F);
        chk("mul_busy_at_done", Busy, 1);
        @(negedge Clk);
        chk("mul_busy_after", Busy, 0);
        chk("mul_done_pulse", Done, 0);

        do_op(2'b01, 32'hFFFFFFFE, 32'd3);
        chk("mul_neg_hilo", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFA);

        do_op(2'b10, 32'd17, 32'd5);
        chk("div_lat", lat, 37);
        chk("div_dctl_cycles", n_dctl, 33);
        chk("div_mul_untouched", n_mctl + n_mrst, 0);
        chk("div_hilo", {Hi, Lo}, 64'h00000002_00000003);

        do_op(2'b10, 32'd7, 32'd0);
        chk("dz_lat", lat, 1);
        chk("dz_flag", DivZero, 1);
        chk("dz_hilo", {Hi, Lo}, 64'h00000002_00000003);
        chk("dz_untouched", n_drst + n_dctl + n_mrst + n_mctl, 0);

        div_never = 1'b1;
        do_op(2'b10, 32'd9, 32'd4);
        chk("to_lat", lat, 43);
        chk("to_flag", Timeout, 1);
        chk("to_dz_cleared", DivZero, 0);
        chk("to_hilo", {Hi, Lo}, 64'h00000002_00000003);
        div_never = 1'b0;

        do_op(2'b01, 32'd2, 32'd3);
        chk("to_cleared", Timeout, 0);
        chk("mul6_lo", Lo, 6);

        // Reset in the middle of RUN
        @(negedge Clk); Req = 1'b1; Op = 2'b01; OpA = 32'd9; OpB = 32'd9;
        @(negedge Clk); Req = 1'b0;
        repeat (9) @(negedge Clk);
        chk("mid_run_ctl", MultControl, 1);
        #2 Reset = 1'b1;
        #1;
        chk("arst_busy", Busy, 0);
        chk("arst_ctl", MultControl, 0);
        chk("arst_mreset", MultReset, 1);
        chk("arst_hilo", {Hi, Lo}, 0);
        chk("arst_unit", UnitA, 0);
        @(negedge Clk); Reset = 1'b0;
        do_op(2'b01, 32'd2, 32'd2);
        chk("post_rst_lat", lat, 37);
        chk("post_rst_lo", Lo, 4);

        // Req held through DONE, plus a stray pulse during RUN
        @(negedge Clk); Req = 1'b1; Op = 2'b01; OpA = 32'd4; OpB = 32'd5;
        dn = 0; d1 = 0; d2 = 0;
        for (int c = 1; c <= 120; c++) begin
            @(negedge Clk);
            if (c == 38) chk("b2b_idle_gap", Busy, 0);
            if (c == 39) begin
                Req = 1'b0;
                chk("b2b_second_clear", MultReset, 1);
            end
            if (c == 50) Req = 1'b1;
            if (c == 51) Req = 1'b0;
            if (Done) begin
                dn++;
                if (dn == 1) d1 = c;
                if (dn == 2) d2 = c;
                $display("b2b done #%0d at cycle %0d Lo=0x%08h", dn, c, Lo);
            end
        end
        chk("b2b_done_count", dn, 2);
        chk("b2b_first_done", d1, 37);
        chk("b2b_second_done", d2, 75);
        chk("b2b_lo", Lo, 20);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
